tdm_demux: RTL and testbench

Receive-side counterpart of the four-input select mux. Takes a time-division-multiplexed stream of WIDTH-bit words, one per valid beat, with a start-of-frame marker on slot 0. Deinterleaves the four slots back into parallel channels a, b, c, d and presents them together, updated atomically once per complete frame. Sits at the far end of a serial link fed by the mux, rebuilding the original four channel buses.

---
 rtl/tdm_pkg.sv | 6 +
 rtl/tdm_demux.sv | 73 +++++++
 tb/tb_tdm_demux.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: framing types and constants shared by the TDM mux and demux
package tdm_pkg;
   localparam int NUM_SLOTS = 4;
   typedef logic [1:0] slot_t;
   typedef enum logic [0:0] {HUNT = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/tdm_demux.sv
// tdm_demux: deinterleave a 4-slot TDM stream into parallel channels, updated once per whole frame
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sof,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic             frame_valid,
   output logic             locked,
   output logic             sync_err
);
   state_t           state;
   slot_t            slot;
   logic [WIDTH-1:0] sh0, sh1, sh2;

   assign locked = state == LOCKED;

   // Framing FSM: shadow slots 0..2, publish all four channels on the slot-3 beat
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= HUNT;
         slot        <= '0;
         sh0         <= '0;
         sh1         <= '0;
         sh2         <= '0;
         a           <= '0;
         b           <= '0;
         c           <= '0;
         d           <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         if (din_valid) begin
            if (state == HUNT) begin
               if (sof) begin
                  sh0   <= din;
                  slot  <= 2'd1;
                  state <= LOCKED;
               end
            end else if (sof) begin
               // sof always restarts the frame; mid-frame it also flags the lost partial frame
               sync_err <= slot != 2'd0;
               sh0      <= din;
               slot     <= 2'd1;
            end else if (slot == 2'd0) begin
               sync_err <= 1'b1;
               state    <= HUNT;
            end else if (slot == 2'd3) begin
               a           <= sh0;
               b           <= sh1;
               c           <= sh2;
               d           <= din;
               frame_valid <= 1'b1;
               slot        <= 2'd0;
            end else begin
               if (slot == 2'd1) sh1 <= din;
               else sh2 <= din;
               slot <= slot + 2'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: directed test-plan scenarios plus random traffic against a frame-level reference model
module tb_tdm_demux;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] din = '0;
   logic       din_valid = 1'b0;
   logic       sof = 1'b0;
   logic [3:0] a, b, c, d;
   logic       frame_valid, locked, sync_err;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: aligned flag, words of the frame in progress, last published frame
   bit         m_locked;
   logic [3:0] m_q[$];
   logic [3:0] m_out[4];
   bit         m_fv, m_err;

   tdm_demux #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
      .a(a), .b(b), .c(c), .d(d),
      .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model(input bit r, input bit v, input bit s, input logic [3:0] w);
      m_fv  = 0;
      m_err = 0;
      if (r) begin
         m_locked = 0;
         m_q.delete();
         foreach (m_out[i]) m_out[i] = '0;
      end else if (v) begin
         if (!m_locked) begin
            if (s) begin
               m_locked = 1;
               m_q = '{w};
            end
         end else if (s) begin
            m_err = m_q.size() != 0;
            m_q = '{w};
         end else if (m_q.size() == 0) begin
            m_err = 1;
            m_locked = 0;
         end else begin
            m_q.push_back(w);
            if (m_q.size() == 4) begin
               foreach (m_out[i]) m_out[i] = m_q[i];
               m_fv = 1;
               m_q.delete();
            end
         end
      end
   endtask

   task automatic cyc(input bit r, input bit v, input bit s, input logic [3:0] w);
      rst = r;
      din_valid = v;
      sof = s;
      din = w;
      @(posedge clk);
      #1;
      model(r, v, s, w);
      chk("a", a, m_out[0]);
      chk("b", b, m_out[1]);
      chk("c", c, m_out[2]);
      chk("d", d, m_out[3]);
      chk("frame_valid", frame_valid, m_fv);
      chk("sync_err", sync_err, m_err);
      chk("locked", locked, m_locked);
      chk("pulse_excl", frame_valid & sync_err, 0);
   endtask

   task automatic beat(input bit s, input logic [3:0] w, input int gap = 0);
      cyc(0, 1, s, w);
      for (int i = 0; i < gap; i++) cyc(0, 0, $urandom_range(0, 1), 4'($urandom));
   endtask

   initial begin
      cyc(1, 1, 1, 4'h7);
      chk("rst_a", a, 0);
      chk("rst_locked", locked, 0);
      // one frame
      beat(1, 4'hA); beat(0, 4'h3); beat(0, 4'h5); beat(0, 4'hC);
      chk("f1_abcd", {a, b, c, d}, 16'hA35C);
      chk("f1_fv", frame_valid, 1);
      cyc(0, 0, 0, 0);
      chk("f1_fv_once", frame_valid, 0);
      // gapped frame
      beat(1, 4'hA, 2); beat(0, 4'h3, 2); beat(0, 4'h5, 2);
      chk("gap_hold", {a, b, c, d}, 16'hA35C);
      beat(0, 4'hC);
      chk("gap_fv", frame_valid, 1);
      // pre-lock junk
      cyc(1, 0, 0, 0);
      beat(0, 4'h1);
      chk("junk_err", sync_err, 0);
      beat(0, 4'h2);
      beat(1, 4'h9); beat(0, 4'h8); beat(0, 4'h7); beat(0, 4'h6);
      chk("junk_abcd", {a, b, c, d}, 16'h9876);
      // early sof
      beat(1, 4'h1); beat(0, 4'h2); beat(0, 4'h3); beat(0, 4'h4);
      beat(1, 4'h5); beat(0, 4'h6); beat(1, 4'h7);
      chk("early_err", sync_err, 1);
      chk("early_hold", {a, b, c, d}, 16'h1234);
      beat(0, 4'h8); beat(0, 4'h9); beat(0, 4'hA);
      chk("early_abcd", {a, b, c, d}, 16'h789A);
      // missing sof
      beat(0, 4'hF);
      chk("miss_err", sync_err, 1);
      chk("miss_locked", locked, 0);
      chk("miss_hold", {a, b, c, d}, 16'h789A);
      beat(1, 4'hB); beat(0, 4'hC); beat(0, 4'hD); beat(0, 4'hE);
      chk("relock_abcd", {a, b, c, d}, 16'hBCDE);
      // reset mid-frame
      beat(1, 4'h1); beat(0, 4'h2);
      cyc(1, 1, 0, 4'h3);
      chk("mid_rst", {a, b, c, d, locked, frame_valid}, 0);
      beat(0, 4'h4);
      beat(1, 4'h5); beat(0, 4'h6); beat(0, 4'h7); beat(0, 4'h8);
      chk("post_rst_abcd", {a, b, c, d}, 16'h5678);
      // back-to-back frames
      for (int f = 0; f < 3; f++) begin
         beat(1, 4'h1); beat(0, 4'h2); beat(0, 4'h3); beat(0, 4'(f));
         chk("b2b_fv", frame_valid, 1);
      end
      // random traffic, sof mostly placed correctly
      for (int i = 0; i < 4000; i++) begin
         bit at0 = m_q.size() == 0;
         bit s = at0 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, s, 4'($urandom));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
